// File: rtl/reg_operand_fetch_if.sv
// Bundle of the request, operand, writeback and register-bank signals
// around reg_operand_fetch. The slave modport is the fetch sequencer itself;
// the master modport is its surroundings (requester, consumer, writeback
// source and the single-port register bank).
interface reg_operand_fetch_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic [REG_AW-1:0]     req_rs1;
    logic [REG_AW-1:0]     req_rs2;
    logic                  req_two_ops;

    logic                  op_valid;
    logic                  op_ready;
    logic [DATA_WIDTH-1:0] op_rs1_value;
    logic [DATA_WIDTH-1:0] op_rs2_value;

    logic                  wb_valid;
    logic                  wb_ready;
    logic [REG_AW-1:0]     wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;

    logic [REG_AW-1:0]     bank_reg_num;
    logic                  bank_write_enable;
    logic [DATA_WIDTH-1:0] bank_data_in;
    logic [DATA_WIDTH-1:0] bank_data_out;

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_two_ops,
        output req_ready,
        output op_valid, op_rs1_value, op_rs2_value,
        input  op_ready,
        input  wb_valid, wb_rd, wb_data,
        output wb_ready,
        output bank_reg_num, bank_write_enable, bank_data_in,
        input  bank_data_out
    );

    modport master (
        output req_valid, req_rs1, req_rs2, req_two_ops,
        input  req_ready,
        input  op_valid, op_rs1_value, op_rs2_value,
        output op_ready,
        output wb_valid, wb_rd, wb_data,
        input  wb_ready,
        input  bank_reg_num, bank_write_enable, bank_data_in,
        output bank_data_out
    );
endinterface

// File: rtl/reg_operand_fetch.sv
// Operand-fetch sequencer in front of the single-port register bank.
// Reads rs1 (and optionally rs2) one per cycle over the shared port, holds
// them on a valid/ready output, and gives writeback priority over new reads.
module reg_operand_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 4
) (
    input  logic               clk,
    input  logic               reset,
    reg_operand_fetch_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RD1,
        RD2,
        DONE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [REG_AW-1:0]     rs1_q;
    logic [REG_AW-1:0]     rs2_q;
    logic                  two_ops_q;
    logic [DATA_WIDTH-1:0] op_rs1_q;
    logic [DATA_WIDTH-1:0] op_rs2_q;

    assign bus.op_rs1_value = op_rs1_q;
    assign bus.op_rs2_value = op_rs2_q;

    // Next state, handshakes and bank port drive; everything is forced low while reset is high.
    always_comb begin
        state_d               = state_q;
        bus.req_ready         = 1'b0;
        bus.wb_ready          = 1'b0;
        bus.op_valid          = 1'b0;
        bus.bank_reg_num      = '0;
        bus.bank_write_enable = 1'b0;
        bus.bank_data_in      = '0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    bus.wb_ready  = 1'b1;
                    bus.req_ready = !bus.wb_valid;
                    if (bus.wb_valid) begin
                        bus.bank_reg_num      = bus.wb_rd;
                        bus.bank_data_in      = bus.wb_data;
                        bus.bank_write_enable = (bus.wb_rd != '0);
                    end else if (bus.req_valid) begin
                        state_d = RD1;
                    end
                end
                RD1: begin
                    bus.bank_reg_num = rs1_q;
                    state_d          = two_ops_q ? RD2 : DONE;
                end
                RD2: begin
                    bus.bank_reg_num = rs2_q;
                    state_d          = DONE;
                end
                DONE: begin
                    bus.op_valid = 1'b1;
                    bus.wb_ready = 1'b1;
                    if (bus.wb_valid) begin
                        bus.bank_reg_num      = bus.wb_rd;
                        bus.bank_data_in      = bus.wb_data;
                        bus.bank_write_enable = (bus.wb_rd != '0);
                    end
                    if (bus.op_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register, request latches and operand capture from the bank read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rs1_q     <= '0;
            rs2_q     <= '0;
            two_ops_q <= 1'b0;
            op_rs1_q  <= '0;
            op_rs2_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && !bus.wb_valid) begin
                        rs1_q     <= bus.req_rs1;
                        rs2_q     <= bus.req_rs2;
                        two_ops_q <= bus.req_two_ops;
                        op_rs2_q  <= '0;
                    end
                end
                RD1:     op_rs1_q <= bus.bank_data_out;
                RD2:     op_rs2_q <= bus.bank_data_out;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Self-checking bench for reg_operand_fetch with a behavioural register bank.
module tb_reg_operand_fetch;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    reg_operand_fetch_if #(.DATA_WIDTH(32), .REG_AW(4)) bus ();

    reg_operand_fetch #(.DATA_WIDTH(32), .REG_AW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Bank: x0 reads 0; unwritten xN reads 0x100+N; writes commit at posedge.
    logic [31:0] mem [16] = '{default: '0};
    logic [15:0] written = '0;

    assign bus.bank_data_out = (bus.bank_reg_num == 4'd0) ? 32'd0 :
                               written[bus.bank_reg_num] ? mem[bus.bank_reg_num] :
                               {28'h0000010, bus.bank_reg_num};

    always @(posedge clk) begin
        if (bus.bank_write_enable) begin
            mem[bus.bank_reg_num]     <= bus.bank_data_in;
            written[bus.bank_reg_num] <= 1'b1;
        end
    end

    function automatic logic [31:0] peek(input logic [3:0] r);
        if (r == 4'd0) return 32'd0;
        return written[r] ? mem[r] : {28'h0000010, r};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Writeback in IDLE or DONE; starts and ends between edges.
    task automatic do_wb(input logic [3:0] rd, input logic [31:0] data, input string nm);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_data  = data;
        #1;
        check({nm, " wb_ready"}, 32'(bus.wb_ready), 32'd1);
        check({nm, " bank_we"}, 32'(bus.bank_write_enable), (rd != 4'd0) ? 32'd1 : 32'd0);
        check({nm, " bank_reg_num"}, 32'(bus.bank_reg_num), 32'(rd));
        check({nm, " bank_data_in"}, bus.bank_data_in, data);
        @(posedge clk); #1;
        bus.wb_valid = 1'b0;
        #1;
    endtask

    task automatic do_fetch(input logic [3:0] rs1, input logic [3:0] rs2, input bit two,
                            input logic [31:0] e1, input logic [31:0] e2,
                            input bit consume, input string nm);
        int lat;
        bit drove_rs2;
        bus.req_rs1     = rs1;
        bus.req_rs2     = rs2;
        bus.req_two_ops = two;
        bus.req_valid   = 1'b1;
        #1;
        check({nm, " req_ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        #1;
        lat = 0;
        drove_rs2 = 1'b0;
        while (!bus.op_valid && lat < 10) begin
            if (!two && rs2 != rs1 && bus.bank_reg_num == rs2) drove_rs2 = 1'b1;
            @(posedge clk); #2;
            lat++;
        end
        check({nm, " latency"}, 32'(lat), two ? 32'd2 : 32'd1);
        check({nm, " rs2 not on bank"}, 32'(drove_rs2), 32'd0);
        check({nm, " rs1 value"}, bus.op_rs1_value, e1);
        check({nm, " rs2 value"}, bus.op_rs2_value, e2);
        if (consume) begin
            bus.op_ready = 1'b1;
            @(posedge clk); #1;
            bus.op_ready = 1'b0;
            #1;
            check({nm, " op_valid drop"}, 32'(bus.op_valid), 32'd0);
        end
    endtask

    typedef struct {
        bit          do_wb;
        logic [3:0]  wb_rd;
        logic [31:0] wb_data;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        bit          two;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 4'd5,  32'hDEADBEEF, 4'd5,  4'd0,  1'b1, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 4'd0,  32'h0,        4'd2,  4'd5,  1'b1, 32'h00000102, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 4'd7,  32'h00001234, 4'd7,  4'd9,  1'b0, 32'h00001234, 32'h0};
        vecs[3] = '{1'b1, 4'd15, 32'hA5A5A5A5, 4'd15, 4'd15, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[4] = '{1'b1, 4'd0,  32'h0000FFFF, 4'd0,  4'd0,  1'b1, 32'h0,        32'h0};

        bus.req_valid = 1'b0; bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_two_ops = 1'b0;
        bus.op_ready = 1'b0; bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;

        // Reset: outputs held low even with requests pending
        @(posedge clk); #1;
        bus.wb_valid = 1'b1; bus.wb_rd = 4'd3; bus.wb_data = 32'h55; bus.req_valid = 1'b1;
        #1;
        check("rst wb_ready", 32'(bus.wb_ready), 32'd0);
        check("rst req_ready", 32'(bus.req_ready), 32'd0);
        check("rst bank_we", 32'(bus.bank_write_enable), 32'd0);
        check("rst bank_reg_num", 32'(bus.bank_reg_num), 32'd0);
        check("rst bank_data_in", bus.bank_data_in, 32'd0);
        check("rst op_valid", 32'(bus.op_valid), 32'd0);
        check("rst rs1", bus.op_rs1_value, 32'd0);
        check("rst rs2", bus.op_rs2_value, 32'd0);
        bus.wb_valid = 1'b0; bus.req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("idle req_ready", 32'(bus.req_ready), 32'd1);
        check("idle wb_ready", 32'(bus.wb_ready), 32'd1);

        // Table-driven writeback + fetch vectors
        for (int unsigned i = 0; i < 5; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            if (vecs[i].do_wb) do_wb(vecs[i].wb_rd, vecs[i].wb_data, nm);
            do_fetch(vecs[i].rs1, vecs[i].rs2, vecs[i].two, vecs[i].exp1, vecs[i].exp2, 1'b1, nm);
        end

        // Same-cycle writeback and request: writeback wins, request next cycle
        bus.wb_valid = 1'b1; bus.wb_rd = 4'd3; bus.wb_data = 32'h11;
        bus.req_valid = 1'b1; bus.req_rs1 = 4'd3; bus.req_rs2 = 4'd0; bus.req_two_ops = 1'b0;
        #1;
        check("raw req_ready", 32'(bus.req_ready), 32'd0);
        check("raw bank_we", 32'(bus.bank_write_enable), 32'd1);
        @(posedge clk); #1;
        bus.wb_valid = 1'b0;
        do_fetch(4'd3, 4'd0, 1'b0, 32'h11, 32'h0, 1'b1, "raw");

        // Hold in DONE for 5 cycles with a writeback to x7 mid-hold
        do_fetch(4'd7, 4'd2, 1'b1, 32'h1234, 32'h102, 1'b0, "hold");
        do_wb(4'd7, 32'h99, "hold wb");
        for (int unsigned k = 0; k < 4; k++) begin
            check("hold op_valid", 32'(bus.op_valid), 32'd1);
            check("hold rs1", bus.op_rs1_value, 32'h1234);
            check("hold rs2", bus.op_rs2_value, 32'h102);
            @(posedge clk); #2;
        end
        check("hold bank x7", peek(4'd7), 32'h99);
        // Writeback and op handshake complete in the same cycle
        bus.op_ready = 1'b1;
        do_wb(4'd4, 32'h44, "done wb+op");
        bus.op_ready = 1'b0;
        check("done wb+op op_valid", 32'(bus.op_valid), 32'd0);
        do_fetch(4'd7, 4'd4, 1'b1, 32'h99, 32'h44, 1'b1, "refetch");

        // Reset during RD2 with a writeback pending
        bus.req_valid = 1'b1; bus.req_rs1 = 4'd2; bus.req_rs2 = 4'd5; bus.req_two_ops = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.wb_valid = 1'b1; bus.wb_rd = 4'd6; bus.wb_data = 32'h66;
        #1;
        check("rd1 wb_ready", 32'(bus.wb_ready), 32'd0);
        check("rd1 req_ready", 32'(bus.req_ready), 32'd0);
        check("rd1 bank_reg_num", 32'(bus.bank_reg_num), 32'd2);
        @(posedge clk); #1;
        check("rd2 bank_reg_num", 32'(bus.bank_reg_num), 32'd5);
        check("rd2 bank_we", 32'(bus.bank_write_enable), 32'd0);
        reset = 1'b1;
        #1;
        check("midrst op_valid", 32'(bus.op_valid), 32'd0);
        check("midrst wb_ready", 32'(bus.wb_ready), 32'd0);
        check("midrst bank_we", 32'(bus.bank_write_enable), 32'd0);
        check("midrst bank_reg_num", 32'(bus.bank_reg_num), 32'd0);
        check("midrst rs1", bus.op_rs1_value, 32'd0);
        @(posedge clk); #1;
        check("midrst no write x6", peek(4'd6), 32'h106);
        reset = 1'b0;
        bus.wb_valid = 1'b0;
        #1;
        check("post rst idle req_ready", 32'(bus.req_ready), 32'd1);
        do_fetch(4'd5, 4'd2, 1'b1, 32'hDEADBEEF, 32'h102, 1'b1, "post rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
